// File: rtl/mem_dma_pkg.sv
// Shared definitions for the mem_dma block-copy engine: FSM encoding,
// copy direction and the request range check.
package mem_dma_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t COPY  = 2'd1;
  localparam state_t DRAIN = 2'd2;

  typedef enum logic {ASC = 1'b0, DESC = 1'b1} dir_e;

  // True when the window [base, base+len) lies inside a memory of 'lines' words.
  function automatic logic range_ok(input int unsigned base,
                                    input int unsigned len,
                                    input int unsigned lines);
    return (base + len) <= lines;
  endfunction

endpackage

// File: rtl/mem_dma_if.sv
// Memory-side bus of mem_dma: combinational read on port A, synchronous write on port B.
interface mem_dma_if #(
  parameter int dtype    = 16,
  parameter int addr_len = 10
);
  logic [addr_len-1:0] rd_addr;
  logic [dtype-1:0]    rd_data;
  logic                wr_en;
  logic [addr_len-1:0] wr_addr;
  logic [dtype-1:0]    wr_data;

  modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data);
  modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/mem_dma.sv
// Block-copy engine: reads through port A, writes one cycle later through port B,
// choosing the copy direction so overlapping regions are copied correctly.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int dtype    = 16,
  parameter int lines    = 1000,
  parameter int addr_len = $clog2(lines)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                start,
  input  logic [addr_len-1:0] src_addr,
  input  logic [addr_len-1:0] dst_addr,
  input  logic [addr_len:0]   length,
  output logic                busy,
  output logic                done,
  output logic                error,
  mem_dma_if.master           mem
);

  localparam int XW = addr_len + 2;

  state_t              state_q, state_d;
  dir_e                dir_q, dir_d;
  logic [addr_len-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_len-1:0] dptr_q, dptr_d;
  logic [addr_len:0]   cnt_q, cnt_d;
  logic                wvalid_q, wvalid_d;
  logic [addr_len-1:0] waddr_q, waddr_d;
  logic [dtype-1:0]    wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [XW-1:0]       src_end;
  logic [addr_len-1:0] src_last, dst_last;
  logic                req_ok, desc_req;

  // Widened so src+length cannot overflow before the range comparison.
  assign src_end  = XW'(src_addr) + XW'(length);
  assign src_last = src_addr + length[addr_len-1:0] - 1'b1;
  assign dst_last = dst_addr + length[addr_len-1:0] - 1'b1;
  assign req_ok   = range_ok(32'(src_addr), 32'(length), 32'(lines)) &&
                    range_ok(32'(dst_addr), 32'(length), 32'(lines));
  assign desc_req = (dst_addr > src_addr) && (XW'(dst_addr) < src_end);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    rd_ptr_d = rd_ptr_q;
    dptr_d   = dptr_q;
    cnt_d    = cnt_q;
    wvalid_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!req_ok) begin
            error_d = 1'b1;
          end else if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = COPY;
            dir_d    = desc_req ? DESC : ASC;
            rd_ptr_d = desc_req ? src_last : src_addr;
            dptr_d   = desc_req ? dst_last : dst_addr;
            cnt_d    = length;
          end
        end
      end
      COPY: begin
        wvalid_d = 1'b1;
        wdata_d  = mem.rd_data;
        waddr_d  = dptr_q;
        cnt_d    = cnt_q - 1'b1;
        // Pointers hold on the last read so they never leave the valid window.
        if (cnt_q == (addr_len+1)'(1)) begin
          state_d = DRAIN;
        end else if (dir_q == DESC) begin
          rd_ptr_d = rd_ptr_q - 1'b1;
          dptr_d   = dptr_q - 1'b1;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          dptr_d   = dptr_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dir_q    <= ASC;
      rd_ptr_q <= '0;
      dptr_q   <= '0;
      cnt_q    <= '0;
      wvalid_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      rd_ptr_q <= rd_ptr_d;
      dptr_q   <= dptr_d;
      cnt_q    <= cnt_d;
      wvalid_q <= wvalid_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign error       = error_q;
  assign mem.rd_addr = rd_ptr_q;
  assign mem.wr_en   = wvalid_q & clk_en;
  assign mem.wr_addr = waddr_q;
  assign mem.wr_data = wdata_q;

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: table vectors, random requests and corner
// sequences checked against a memmove-style reference model.
module tb_mem_dma;

  localparam int DTYPE = 16;
  localparam int LINES = 1000;
  localparam int AW    = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clk_en = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, error;

  int checks = 0;
  int errors = 0;

  mem_dma_if #(.dtype(DTYPE), .addr_len(AW)) bus ();

  mem_dma #(.dtype(DTYPE), .lines(LINES), .addr_len(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .clk_en   (clk_en),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .mem      (bus)
  );

  always #5 clock = ~clock;

  // Dual-port memory: combinational read, synchronous write, plus a backdoor image load.
  logic [DTYPE-1:0] mem    [0:LINES-1];
  logic [DTYPE-1:0] bd_mem [0:LINES-1];
  logic             bd_load = 1'b0;
  int               wr_log[$];

  assign bus.rd_data = (int'(bus.rd_addr) < LINES) ? mem[bus.rd_addr] : '0;

  always @(posedge clock or posedge bd_load) begin
    if (bd_load) begin
      for (int i = 0; i < LINES; i++) mem[i] <= bd_mem[i];
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
      wr_log.push_back(int'(bus.wr_addr));
    end
  end

  typedef struct {
    int s;
    int d;
    int l;
    bit err;
    int lat;
    int first;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one request starting at a negedge; optional stall, ignored start and mid-copy reset.
  task automatic apply_stimulus(input string tag, input int s, input int d, input int l,
                                input bit exp_err, input int exp_lat, input int exp_first,
                                input int stall_at, input int stall_len,
                                input int ghost_at, input int reset_at);
    logic [DTYPE-1:0] exp_mem [0:LINES-1];
    int copy_n, exp_busy, end_n, busy_n, stall_w0, mism;
    bit got_err, got_done;

    for (int i = 0; i < LINES; i++) bd_mem[i] = DTYPE'($urandom);
    bd_load = 1'b1;
    #1 bd_load = 1'b0;

    copy_n = exp_err ? 0 : ((reset_at > 0) ? reset_at - 2 : l);
    for (int i = 0; i < LINES; i++) exp_mem[i] = bd_mem[i];
    for (int i = 0; i < copy_n; i++) exp_mem[d+i] = bd_mem[s+i];
    exp_busy = (exp_err || l == 0) ? 0 : l + 1 + stall_len;

    wr_log.delete();
    src_addr = AW'(s);
    dst_addr = AW'(d);
    length   = (AW+1)'(l);
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;

    end_n = -1; busy_n = 0; got_err = 0; got_done = 0; stall_w0 = 0;
    for (int n = 1; n <= 3000; n++) begin
      if (busy) busy_n++;
      if (done || error) begin
        got_done = done;
        got_err  = error;
        end_n    = n;
        break;
      end
      if (n == reset_at) begin
        check_output({tag, "_wr_en_pre_reset"}, int'(bus.wr_en), 1);
        check_output({tag, "_wr_addr_pre_reset"}, int'(bus.wr_addr), d + 3);
        reset = 1'b1;
        #1;
        check_output({tag, "_wr_en_in_reset"}, int'(bus.wr_en), 0);
        check_output({tag, "_busy_in_reset"}, int'(busy), 0);
        #1 reset = 1'b0;
        end_n = n;
        break;
      end
      if (n == ghost_at) begin
        start = 1'b1; src_addr = '0; dst_addr = AW'(100); length = (AW+1)'(5);
      end
      if (n == ghost_at + 1) start = 1'b0;
      if (n == stall_at) begin
        clk_en   = 1'b0;
        stall_w0 = wr_log.size();
      end
      if (stall_at > 0 && n == stall_at + stall_len) begin
        clk_en = 1'b1;
        check_output({tag, "_stall_writes"}, wr_log.size() - stall_w0, 0);
      end
      @(negedge clock);
    end

    if (reset_at > 0) begin
      check_output({tag, "_busy_after_reset"}, int'(busy), 0);
    end else begin
      check_output({tag, "_end_cycle"}, end_n, exp_lat);
      check_output({tag, "_error"}, int'(got_err), int'(exp_err));
      check_output({tag, "_done"}, int'(got_done), int'(!exp_err));
      check_output({tag, "_busy_cycles"}, busy_n, exp_busy);
    end
    check_output({tag, "_writes"}, wr_log.size(), copy_n);
    if (exp_first >= 0)
      check_output({tag, "_first_wr"}, (wr_log.size() > 0) ? wr_log[0] : -1, exp_first);
    mism = 0;
    for (int i = 0; i < LINES; i++) if (mem[i] !== exp_mem[i]) mism++;
    check_output({tag, "_mem_image"}, mism, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s, d, l, mode, lat, first;
    bit err;

    vecs[0] = '{100, 500, 4,    1'b0, 6,    500};
    vecs[1] = '{10,  12,  5,    1'b0, 7,    16};
    vecs[2] = '{12,  10,  5,    1'b0, 7,    10};
    vecs[3] = '{998, 0,   3,    1'b1, 1,    -1};
    vecs[4] = '{0,   998, 3,    1'b1, 1,    -1};
    vecs[5] = '{5,   7,   0,    1'b0, 1,    -1};
    vecs[6] = '{997, 0,   3,    1'b0, 5,    0};
    vecs[7] = '{0,   999, 1,    1'b0, 3,    999};
    vecs[8] = '{40,  40,  6,    1'b0, 8,    40};
    vecs[9] = '{0,   0,   1000, 1'b0, 1002, 0};

    repeat (2) @(negedge clock);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_error", int'(error), 0);
    check_output("rst_wr_en", int'(bus.wr_en), 0);
    check_output("rst_rd_addr", int'(bus.rd_addr), 0);
    check_output("rst_wr_addr", int'(bus.wr_addr), 0);
    check_output("rst_wr_data", int'(bus.wr_data), 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 10; i++)
      apply_stimulus($sformatf("vec%0d", i), vecs[i].s, vecs[i].d, vecs[i].l,
                     vecs[i].err, vecs[i].lat, vecs[i].first, -1, 0, -1, -1);

    apply_stimulus("stall", 200, 600, 8, 1'b0, 13, 600, 3, 3, -1, -1);
    apply_stimulus("busy_start", 300, 700, 6, 1'b0, 8, 700, -1, 0, 2, -1);
    apply_stimulus("mid_reset", 200, 600, 8, 1'b0, 0, 600, -1, 0, -1, 5);
    @(negedge clock);

    for (int r = 0; r < 24; r++) begin
      l    = $urandom_range(0, 40);
      s    = $urandom_range(0, 999);
      mode = $urandom_range(0, 3);
      case (mode)
        0:       d = $urandom_range(0, 999);
        1:       d = s + $urandom_range(0, l);
        2:       d = s - $urandom_range(0, l);
        default: d = s;
      endcase
      if (d < 0) d = 0;
      if (d > 999) d = 999;
      err   = (s + l > LINES) || (d + l > LINES);
      lat   = (err || l == 0) ? 1 : l + 2;
      first = (err || l == 0) ? -1 : ((d > s && d < s + l) ? d + l - 1 : d);
      apply_stimulus($sformatf("rnd%0d", r), s, d, l, err, lat, first, -1, 0, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Block-copy engine that acts as the initiator for the team's dual-port memory (combinational read, synchronous write).
- Copies `length` consecutive words from `src_addr` to `dst_addr`. Reads through memory port A and writes through memory port B.
- Handles overlapping regions correctly by choosing the copy direction.
- Sits between the control sequencer (start/done handshake) and one memory instance.

Parameters:
- dtype, 16, data word width; must match the memory's dtype.
- lines, 1000, memory depth in words.
- addr_len, $clog2(lines), memory address width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clk_en  input  1  engine advance enable; when low, all state freezes.
- start  input  1  copy request, sampled in IDLE only.
- src_addr  input  addr_len  first source word.
- dst_addr  input  addr_len  first destination word.
- length  input  addr_len+1  word count, 0..lines.
- busy  output  1  high while a copy is in progress.
- done  output  1  one-cycle pulse on successful completion, including length 0.
- error  output  1  one-cycle pulse when a request is rejected for range.
- mem_rd_addr  output  addr_len  drives memory Address_A.
- mem_rd_data  input  dtype  from memory Out_A, same-cycle.
- mem_wr_en  output  1  drives memory write_B.
- mem_wr_addr  output  addr_len  drives memory Address_B.
- mem_wr_data  output  dtype  drives memory Data_B.
- Memory write_A is tied 0 at the instantiating level; the engine never writes through port A.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - busy, done, error and mem_wr_en all go to 0.
  - mem_rd_addr, mem_wr_addr and mem_wr_data go to 0.
  - Reset mid-copy aborts the copy; partial writes stay in memory.
- clk_en low:
  - No register updates.
  - mem_wr_en = wvalid_q AND clk_en, so no write lands while frozen.
  - The pending write is issued when clk_en returns high.
- Range check (IDLE, on start with clk_en high). Arithmetic is done in addr_len+2 bits:
  - Reject if src_addr+length > lines or dst_addr+length > lines.
  - On reject: error pulses the next cycle, no memory writes occur, and the engine stays in IDLE.
  - If length==0: done pulses the next cycle with no writes.
- Direction:
  - Descending when dst_addr > src_addr and dst_addr < src_addr+length.
  - Ascending otherwise, including dst_addr==src_addr.
  - Descending pointers start at src_addr+length-1 and dst_addr+length-1.
- FSM:
  - IDLE -> COPY on an accepted start.
  - COPY -> DRAIN after the last read is issued.
  - DRAIN -> IDLE after the last write is issued, with done pulsing on that transition.
  - start is ignored while busy.
- Pipeline:
  - Cycle k of COPY (k=0..length-1): mem_rd_addr = rd_ptr.
  - At the clock edge, mem_rd_data, the destination pointer and wvalid are registered.
  - Write k is presented in cycle k+1.
  - A read never observes the write landing at the same edge; old data is returned, which is correct for both directions.
- Latency and handshake:
  - Start is accepted at edge E0.
  - busy is high from cycle E0+1 through the final write cycle E0+length+1.
  - done is high for exactly cycle E0+length+2, with busy low in that cycle.
  - A new start is accepted in the done cycle.
- Pointers:
  - Each pointer steps ±1 per advancing cycle.
  - A valid request never wraps, because range is checked first.
- length==lines with src=dst=0 is legal: a full-memory self-copy with contents unchanged.

Decomposition:
- mem_dma_pkg holds:
  - the state enum {IDLE, COPY, DRAIN};
  - the direction enum {ASC, DESC};
  - a function range_ok(base, len, lines).
- No sub-module; the datapath is one register stage plus counters. Target is roughly 150-220 lines of RTL.
- Bench instantiates mem_dma with the team's Memory model.

Test Plan:
- Non-overlapping copy:
  - Stimulus: memory[100..103] = 1,2,3,4; src=100, dst=500, len=4.
  - Response: memory[500..503] = 1,2,3,4; exactly 4 writes; done at start+6; busy high for 5 cycles.
- Overlap, descending:
  - Stimulus: memory[10..14] = A,B,C,D,E; src=10, dst=12, len=5.
  - Response: memory[12..16] = A..E; first write address is 16.
- Overlap, ascending:
  - Stimulus: same initial data; src=12, dst=10, len=5.
  - Response: memory[10..14] = C,D,E,mem[15],mem[16] (original values); first write address is 10.
- Range and zero length:
  - src=998, len=3 -> error pulse, no writes, busy stays 0.
  - len=0 -> done pulse next cycle, no writes.
  - src=0, len=1000 -> accepted.
- clk_en stall:
  - Stimulus: clk_en low for 3 cycles mid-copy of len=8.
  - Response: no write during the stall; final contents correct; done delayed by exactly 3 cycles.
- Reset and busy interaction:
  - Reset asserted between clock edges at write 3 of len=8 -> mem_wr_en falls immediately, state is IDLE, only writes 0..2 landed.
  - start pulsed while busy -> ignored.
